// File: rtl/xbar_sched_if.sv
// -----------------------------------------------------------------------------
// xbar_sched_if
//   Bundles every signal between the per-layer controllers, the crossbar tile
//   and the xbar_sched scheduler. Clock and reset stay outside the interface.
//
//   Handshake: a word on requester k is transferred on a rising clock edge
//   where i_valid[k] && o_ready[k] are both high. o_ready is only ever high for
//   the granted requester while its load is in progress. A requester may hold
//   i_valid low for any number of cycles (stall) and must hold i_data stable
//   only in the cycle it is transferred. i_valid is ignored while o_ready is low.
//
//   Modports:
//     master - the scheduler (drives o_*, samples i_*)
//     slave  - the environment (controllers + crossbar tile)
//
//   Signals:
//     i_req       [NUM_REQ]              level request per requester
//     i_valid     [NUM_REQ]              per-requester data valid
//     i_data      [NUM_REQ*datatype_size] flattened words, lane k at k*datatype_size
//     o_grant     [NUM_REQ]              registered one-hot grant
//     o_ready     [NUM_REQ]              grant while loading, else 0
//     o_wr_en                            crossbar buffer write strobe
//     o_wr_addr   [ADDR_W]               crossbar buffer address
//     o_wr_data   [datatype_size]        crossbar buffer data
//     o_start_cim                        one-cycle crossbar start
//     i_cim_done                         crossbar completion pulse
//     o_done      [NUM_REQ]              one-cycle done to served requester
//     o_error                            one-cycle watchdog timeout pulse
//     o_busy                             scheduler not idle
//     o_dbg_state [3]                    current FSM state encoding
// -----------------------------------------------------------------------------
interface xbar_sched_if #(
    parameter int NUM_REQ       = 4,
    parameter int datatype_size = 8,
    parameter int xbar_size     = 256
);
    localparam int ADDR_W = $clog2(xbar_size);

    logic [NUM_REQ-1:0]               i_req;
    logic [NUM_REQ-1:0]               i_valid;
    logic [NUM_REQ*datatype_size-1:0] i_data;
    logic [NUM_REQ-1:0]               o_grant;
    logic [NUM_REQ-1:0]               o_ready;
    logic                             o_wr_en;
    logic [ADDR_W-1:0]                o_wr_addr;
    logic [datatype_size-1:0]         o_wr_data;
    logic                             o_start_cim;
    logic                             i_cim_done;
    logic [NUM_REQ-1:0]               o_done;
    logic                             o_error;
    logic                             o_busy;
    logic [2:0]                       o_dbg_state;

    modport master (
        input  i_req, i_valid, i_data, i_cim_done,
        output o_grant, o_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_start_cim, o_done, o_error, o_busy, o_dbg_state
    );

    modport slave (
        output i_req, i_valid, i_data, i_cim_done,
        input  o_grant, o_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_start_cim, o_done, o_error, o_busy, o_dbg_state
    );
endinterface

// File: rtl/xbar_sched.sv
// -----------------------------------------------------------------------------
// xbar_sched
//   Round-robin scheduler sharing one CIM crossbar tile between NUM_REQ layer
//   controllers. Grants one requester, streams its xbar_size words into the
//   crossbar input buffer, pulses start, waits for completion and returns a
//   done pulse to that requester before re-arbitrating.
//
//   Optional feature macro: XBAR_SCHED_TIMEOUT_EN
//     defined   - watchdog in WAIT; after TIMEOUT_CYCLES cycles without
//                 i_cim_done the transaction ends with o_error alongside o_done.
//     undefined - WAIT lasts until i_cim_done; o_error is tied low.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - xbar_sched_if.master (requests, data, crossbar write/start/done,
//            grant/ready/done/error/busy, debug state)
// -----------------------------------------------------------------------------
module xbar_sched #(
    parameter int NUM_REQ        = 4,
    parameter int datatype_size  = 8,
    parameter int xbar_size      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    xbar_sched_if.master  bus
);
    localparam int ADDR_W = $clog2(xbar_size);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(xbar_size - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [PTR_W-1:0]          gidx_q, gidx_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [datatype_size-1:0]  wr_data_q, wr_data_d;

`ifdef XBAR_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      err_q, err_d;
`endif

    logic [NUM_REQ-1:0]        ready;
    logic                      beat_acc;
    logic [datatype_size-1:0]  sel_data;
    logic                      arb_found;
    logic [PTR_W-1:0]          arb_pick;
    int                        arb_idx;

    // Rotating-priority search: first set request at or after the pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!arb_found && bus.i_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = PTR_W'(arb_idx);
            end
        end
    end

    assign ready    = (state_q == S_LOAD) ? grant_q : '0;
    assign beat_acc = |(bus.i_valid & ready);
    assign sel_data = bus.i_data[gidx_q*datatype_size +: datatype_size];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef XBAR_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = NUM_REQ'(1) << arb_pick;
                    gidx_d  = arb_pick;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat_acc) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = sel_data;
                    // Final beat leaves LOAD, so the counter never wraps here.
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef XBAR_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                // A real completion takes priority over a same-cycle timeout.
                if (bus.i_cim_done) begin
                    state_d = S_DONE;
                end
`ifdef XBAR_SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
                cnt_d    = '0;
                state_d  = S_IDLE;
`ifdef XBAR_SCHED_TIMEOUT_EN
                err_d    = 1'b0;
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef XBAR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.o_error = (state_q == S_DONE) && err_q;
`else
    assign bus.o_error = 1'b0;
`endif

    // Outputs decode registered state only, so an asynchronous reset clears
    // them immediately.
    assign bus.o_grant     = grant_q;
    assign bus.o_ready     = ready;
    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_start_cim = (state_q == S_START);
    assign bus.o_done      = (state_q == S_DONE) ? grant_q : '0;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_xbar_sched.sv
module tb_xbar_sched;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int XS = 4;
    localparam int TO = 8;

    logic clk;
    logic rst;

    xbar_sched_if #(.NUM_REQ(NR), .datatype_size(DW), .xbar_size(XS)) bus ();

    xbar_sched #(
        .NUM_REQ(NR), .datatype_size(DW), .xbar_size(XS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr      = 0;              // model round-robin pointer
    logic [DW-1:0] exp_q[$];       // scoreboard of expected buffer writes

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model arbitration: first requesting index at or after the pointer.
    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int i = 0; i < NR; i++) begin
            if (m[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.o_grant), 0);
        chk({tag, "_ready"}, 32'(bus.o_ready), 0);
        chk({tag, "_wr_en"}, 32'(bus.o_wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(bus.o_wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(bus.o_wr_data), 0);
        chk({tag, "_start"}, 32'(bus.o_start_cim), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
        chk({tag, "_error"}, 32'(bus.o_error), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    endtask

    task automatic async_reset;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        bus.i_req = '0; bus.i_valid = '0; bus.i_cim_done = 1'b0;
        #2 rst = 1'b0;
        ptr = 0;
        step();
    endtask

    // One complete transaction.
    //   vlen/vpat : if vlen>0, granted-lane valid follows vpat[cycle] (1 after)
    //   mode 0    : done after d WAIT cycles
    //   mode 1    : async reset after d WAIT cycles
    //   mode 2    : never send done (watchdog behaviour)
    task automatic run_txn(input logic [NR-1:0] mask, input int vlen, input logic [15:0] vpat,
                           input bit fixed_data, input bit drop_req, input bit stray_done,
                           input int mode, input int d);
        int g, beats, cyc;
        logic [NR-1:0] v;
        logic [NR*DW-1:0] dat;
        logic acc;
        g = pick(mask, ptr);
        bus.i_req = mask;
        step();
        chk("grant", 32'(bus.o_grant), 32'(1 << g));
        chk("busy_load", 32'(bus.o_busy), 1);

        beats = 0;
        cyc   = 0;
        while (beats < XS && cyc < 64) begin
            chk("ready", 32'(bus.o_ready), 32'(1 << g));
            v = NR'($urandom_range(0, (1 << NR) - 1));
            if (vlen > 0) v[g] = (cyc < vlen) ? vpat[cyc] : 1'b1;
            else          v[g] = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) dat[k*DW +: DW] = DW'($urandom);
            if (fixed_data) dat[g*DW +: DW] = DW'(8'h11 + beats);
            acc = v[g];
            if (acc) exp_q.push_back(dat[g*DW +: DW]);
            bus.i_valid = v;
            bus.i_data  = dat;
            bus.i_cim_done = (stray_done && cyc == 1);
            if (drop_req && beats == 1) bus.i_req = '0;
            step();
            if (acc) begin
                chk("wr_en", 32'(bus.o_wr_en), 1);
                chk("wr_addr", 32'(bus.o_wr_addr), 32'(beats));
                chk("wr_data", 32'(bus.o_wr_data), 32'(exp_q.pop_front()));
                beats++;
            end else begin
                chk("wr_en_gap", 32'(bus.o_wr_en), 0);
            end
            chk("start", 32'(bus.o_start_cim), 32'(beats == XS));
            cyc++;
        end
        bus.i_valid = '0;
        bus.i_cim_done = 1'b0;
        if (beats < XS) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_budget observed=%0d beats required=%0d", beats, XS);
            return;
        end

        // WAIT cycles
        for (int k = 0; k < ((mode == 2) ? 20 : d); k++) begin
            step();
            chk("wait_start", 32'(bus.o_start_cim), 0);
            chk("wait_done", 32'(bus.o_done), 0);
            chk("wait_busy", 32'(bus.o_busy), 1);
`ifdef XBAR_SCHED_TIMEOUT_EN
            if (mode == 2 && k == TO - 1) break;
`else
            chk("wait_error", 32'(bus.o_error), 0);
`endif
        end

        if (mode == 1) begin
            async_reset();
            return;
        end
        if (mode == 2) begin
`ifdef XBAR_SCHED_TIMEOUT_EN
            step();
            chk("tmo_done", 32'(bus.o_done), 32'(1 << g));
            chk("tmo_error", 32'(bus.o_error), 1);
            ptr = (g + 1) % NR;
            step();
            chk("tmo_idle_busy", 32'(bus.o_busy), 0);
`else
            async_reset();
`endif
            return;
        end

        bus.i_cim_done = 1'b1;
        step();
        bus.i_cim_done = 1'b0;
        chk("done", 32'(bus.o_done), 32'(1 << g));
        chk("done_error", 32'(bus.o_error), 0);
        ptr = (g + 1) % NR;
        step();
        chk("idle_done", 32'(bus.o_done), 0);
        chk("idle_busy", 32'(bus.o_busy), 0);
        chk("idle_grant", 32'(bus.o_grant), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_valid = '0;
        bus.i_data = '0;
        bus.i_cim_done = 1'b0;
        #12;
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // single request with known data, done 3 cycles after WAIT entry
        run_txn(4'b0010, 4, 16'hF, 1'b1, 1'b0, 1'b0, 0, 3);

        // return pointer to 0 so the round order starts from requester 0
        async_reset();
        for (int r = 0; r < 4; r++)
            run_txn(4'b1011, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, int'($urandom_range(1, 4)));

        // stalls 1,0,0,1,1,0,1
        run_txn(4'b0100, 7, 16'b1011001, 1'b0, 1'b0, 1'b0, 0, 2);

        // request dropped after beat 1, stray done during LOAD
        run_txn(4'b0001, 0, 16'h0, 1'b0, 1'b1, 1'b1, 0, 2);

        // done in the last watchdog cycle: done wins, no error
        run_txn(4'b1111, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, TO);

        // random masks
        for (int r = 0; r < 8; r++)
            run_txn(NR'($urandom_range(1, 15)), 0, 16'h0, 1'b0, 1'b0, 1'b0, 0,
                    int'($urandom_range(1, 5)));

        // async reset in WAIT, then pointer must restart at 0
        run_txn(4'b0100, 0, 16'h0, 1'b0, 1'b0, 1'b0, 1, 2);
        run_txn(4'b0011, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1);
        run_txn(4'b0100, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1);

        // no completion from the crossbar
        run_txn(4'b1000, 0, 16'h0, 1'b0, 1'b0, 1'b0, 2, 0);

        // scheduler usable afterwards
        run_txn(4'b1010, 0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xbar_sched.md
# xbar_sched

Round-robin scheduler that shares one CIM crossbar tile between `NUM_REQ` layer controllers. It grants the tile to one requester at a time and streams that requester's `xbar_size` input words into the crossbar input buffer. It then pulses the crossbar start, waits for the crossbar's completion, and returns a per-requester done pulse before re-arbitrating. It sits between the per-layer `ctrl` instances and a single crossbar tile.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `datatype_size`, 8, width of one input word
- `xbar_size`, 256, words per crossbar load (≥2); `ADDR_W = $clog2(xbar_size)`
- `TIMEOUT_CYCLES`, 1024, watchdog limit; used only with `XBAR_SCHED_TIMEOUT_EN`

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_req` in NUM_REQ: level request per requester.
- `i_valid` in NUM_REQ: per-requester data valid.
- `i_data` in NUM_REQ*datatype_size: flattened words; requester k occupies `[k*datatype_size +: datatype_size]`.
- `o_grant` out NUM_REQ: one-hot grant, registered.
- `o_ready` out NUM_REQ: equals `o_grant` while in LOAD, else 0.
- `o_wr_en` out 1: crossbar buffer write strobe.
- `o_wr_addr` out ADDR_W: crossbar buffer address.
- `o_wr_data` out datatype_size: crossbar buffer data.
- `o_start_cim` out 1: one-cycle crossbar start pulse.
- `i_cim_done` in 1: crossbar completion pulse.
- `o_done` out NUM_REQ: one-cycle done pulse to the served requester.
- `o_error` out 1: one-cycle timeout pulse.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: state IDLE; `o_grant`, `o_done`, `o_wr_en`, `o_start_cim`, `o_error` all 0; `o_wr_addr` 0; `o_wr_data` 0; RR pointer 0; beat counter 0.
- States and transitions:
  - IDLE: if `i_req != 0`, pick the first set bit at or after the RR pointer (wrapping) → register the one-hot grant and go to LOAD.
  - LOAD: a beat is accepted when `i_valid[g] && o_ready[g]`. The accepted word is written at counter address, then the counter increments. Acceptance of beat `xbar_size-1` → START.
  - START: `o_start_cim`=1 for one cycle → WAIT.
  - WAIT: `i_cim_done`=1 → DONE.
  - DONE: `o_done[g]`=1 for one cycle; grant cleared; RR pointer = (g+1) mod NUM_REQ; counter reset → IDLE.
- Once granted, the transaction completes regardless of `i_req`. Deasserting `i_req[g]` mid-transaction has no effect.
- `i_valid` from non-granted requesters is ignored. A LOAD gap (valid low) stalls with no write.
- `i_cim_done` outside WAIT is ignored.
- Counter width is ADDR_W. It never wraps in LOAD, because the final beat exits the state.
- Reset asserted in any state aborts the transaction immediately. No done pulse is issued. All outputs return to their reset values.

## Timing
- Request in IDLE at edge t → `o_grant`/`o_ready` high from t+1. Minimum arbitration latency is 1 cycle.
- Beat accepted at edge t → `o_wr_en`, `o_wr_addr`, `o_wr_data` valid during cycle t+1 (registered, 1-cycle latency).
- The last beat accepted at edge t puts START in cycle t+1, concurrent with the last `o_wr_en`. The crossbar samples start no earlier than the final write.
- `i_cim_done` seen at edge t → DONE in cycle t+1 → IDLE in cycle t+2. A new grant can appear in cycle t+3.
- Minimum transaction with no stalls: 1 + xbar_size + 1 + WAIT + 1 cycles.

## Configuration
- `XBAR_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `i_cim_done` is not seen within `TIMEOUT_CYCLES` cycles, go to DONE with `o_error`=1 in the same cycle as `o_done[g]`.
  - The counter clears on entry to WAIT.
  - If done and timeout coincide, done wins and `o_error` stays 0.
- Undefined: WAIT lasts indefinitely; `o_error` is tied to 0; no counter logic.

## Test plan
(`NUM_REQ`=4, `xbar_size`=4, `TIMEOUT_CYCLES`=8)
- Reset, then single request: `i_req`=0b0010, data 0x11..0x14 with valid every cycle → `o_grant`=0b0010; writes addr 0..3 data 0x11..0x14; one `o_start_cim`. `i_cim_done` 3 cycles later → `o_done`=0b0010 for one cycle; `o_busy` falls.
- Contention: `i_req`=0b1011 held → grant order 0b0001, 0b0010, 0b1000, 0b0001; each served exactly once per round.
- Stalls: `i_valid` toggled 1,0,0,1,1,0,1 → exactly 4 writes at addrs 0..3 in order; no write on gap cycles; start follows the 4th beat.
- Mid-transaction: `i_req` dropped after beat 1 and stray `i_cim_done` pulsed during LOAD → load completes, the stray done is ignored, and the transaction finishes normally.
- Async reset asserted in WAIT between clock edges → all outputs 0 immediately; the next `i_req`=0b0100 is granted from pointer 0.
- With `XBAR_SCHED_TIMEOUT_EN`: no `i_cim_done` → after 8 WAIT cycles `o_error` and `o_done[g]` pulse together. Without the macro → stays in WAIT, `o_error` stays 0.
